// File: rtl/etx_arbiter_pkg.sv
// Shared definitions for the etx arbiter: requester indices, packet bit
// positions and small helpers used by the arbiter and its picker.
package etx_arbiter_pkg;

    // Requester index; also the bit position in the elig/grant vectors.
    typedef logic [1:0] req_idx_t;

    localparam req_idx_t RR = 2'd0;  // read response (write-class)
    localparam req_idx_t RD = 2'd1;  // read request  (read-class)
    localparam req_idx_t WR = 2'd2;  // write request (write-class)

    localparam int NREQ = 3;

    // Bit of an emesh packet that marks a write-class transaction.
    localparam int PKT_WRITE_BIT = 0;

    // Write-class requesters are the ones blocked by etx_wr_wait.
    function automatic logic is_write_class(input req_idx_t idx);
        return (idx != RD);
    endfunction

    // Round-robin successor in the order rr -> rd -> wr -> rr.
    function automatic req_idx_t next_idx(input req_idx_t idx);
        req_idx_t n;
        case (idx)
            RR:      n = RD;
            RD:      n = WR;
            default: n = RR;
        endcase
        return n;
    endfunction

    // One-hot vector for a requester index (out-of-range gives zero).
    function automatic logic [NREQ-1:0] onehot(input req_idx_t idx);
        logic [NREQ-1:0] v;
        case (idx)
            RR:      v = 3'b001;
            RD:      v = 3'b010;
            WR:      v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-input round-robin picker with a lock override. While lock is set
// and the owner is still eligible the owner keeps the grant; otherwise the
// search starts at the requester after 'last' and wraps, so 'last' itself
// is the lowest priority candidate. Purely combinational.
module rr_arbiter3
    import etx_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] elig,
    input  req_idx_t        last,
    input  logic            lock,
    input  req_idx_t        owner,
    output logic [NREQ-1:0] grant
);

    req_idx_t w_first;
    req_idx_t w_second;
    logic     w_owner_elig;

    assign w_first      = next_idx(last);
    assign w_second     = next_idx(w_first);
    assign w_owner_elig = |(elig & onehot(owner));

    // Pick the lock owner if it may continue, else the first eligible in rotation.
    always_comb begin
        grant = '0;
        if (lock && w_owner_elig) begin
            grant = onehot(owner);
        end else if (|(elig & onehot(w_first))) begin
            grant = onehot(w_first);
        end else if (|(elig & onehot(w_second))) begin
            grant = onehot(w_second);
        end else if (|(elig & onehot(last))) begin
            grant = onehot(last);
        end
    end

endmodule

// File: rtl/etx_arbiter.sv
// Merges the txwr / txrd / txrr emesh streams into one registered
// etx_access/etx_packet channel in front of etx_protocol.
//
// Handshake: every requester follows emesh valid/wait. It presents access
// and packet and holds them while its wait is high; a transfer happens in
// any cycle with access=1 and wait=0. Downstream, the registered packet is
// taken in any cycle where etx_access=1 and the class wait selected by the
// packet's write bit is low.
//
// Write-class grants to the same requester are chained (up to BURST) so
// etx_protocol sees back-to-back writes and can form bursts.
module etx_arbiter
    import etx_arbiter_pkg::*;
#(
    parameter int PW    = 104,
    parameter int BURST = 16
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_enable,
    input  logic          txwr_access,
    input  logic [PW-1:0] txwr_packet,
    output logic          txwr_wait,
    input  logic          txrd_access,
    input  logic [PW-1:0] txrd_packet,
    output logic          txrd_wait,
    input  logic          txrr_access,
    input  logic [PW-1:0] txrr_packet,
    output logic          txrr_wait,
    output logic          etx_access,
    output logic [PW-1:0] etx_packet,
    input  logic          etx_wr_wait,
    input  logic          etx_rd_wait
);

    localparam int             CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BURST);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    // Output register and arbitration state.
    logic            r_access;
    logic [PW-1:0]   r_packet;
    req_idx_t        r_last;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_load;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic            w_any_grant;
    logic            w_lock;
    req_idx_t        w_grant_idx;
    logic [PW-1:0]   w_grant_pkt;
    logic [CW-1:0]   w_cnt_next;

    // Downstream takes the registered packet when its class is not pushing back.
    assign w_accept = r_access &
                      ~(r_packet[PKT_WRITE_BIT] ? etx_wr_wait : etx_rd_wait);

    // The output register may be refilled when empty or being drained.
    assign w_load = ~r_access | w_accept;

    // Eligibility: requesting, enabled, and its class not blocked downstream.
    assign w_elig[RR] = txrr_access & tx_enable & ~etx_wr_wait;
    assign w_elig[RD] = txrd_access & tx_enable & ~etx_rd_wait;
    assign w_elig[WR] = txwr_access & tx_enable & ~etx_wr_wait;

    // The owner is the last granted requester; only write-class owners lock,
    // and a zero count means the chain was broken by an idle load.
    assign w_lock = is_write_class(r_last) & (r_cnt != '0) & (r_cnt < CNT_MAX);

    rr_arbiter3 u_rr_arbiter3 (
        .elig  (w_elig),
        .last  (r_last),
        .lock  (w_lock),
        .owner (r_last),
        .grant (w_grant)
    );

    assign w_any_grant = |w_grant;

    // Encode the one-hot grant and select the granted packet.
    always_comb begin
        w_grant_idx = RR;
        w_grant_pkt = txrr_packet;
        if (w_grant[RD]) begin
            w_grant_idx = RD;
            w_grant_pkt = txrd_packet;
        end else if (w_grant[WR]) begin
            w_grant_idx = WR;
            w_grant_pkt = txwr_packet;
        end
    end

    // A requester transfers only when its grant is actually captured;
    // reset forces every requester to stall.
    assign txrr_wait = reset | ~(w_load & w_grant[RR]);
    assign txrd_wait = reset | ~(w_load & w_grant[RD]);
    assign txwr_wait = reset | ~(w_load & w_grant[WR]);

    // Burst count: extend on a repeat write-class grant, restart on a new
    // owner, clear on a load with no grant. Saturates instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_load) begin
            if (!w_any_grant) begin
                w_cnt_next = '0;
            end else if (is_write_class(w_grant_idx) && (w_grant_idx == r_last)) begin
                w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
            end else begin
                w_cnt_next = CNT_ONE;
            end
        end
    end

    // Output register, round-robin pointer and burst counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_access <= 1'b0;
            r_packet <= '0;
            r_last   <= WR;
            r_cnt    <= '0;
        end else begin
            if (w_load) begin
                r_access <= w_any_grant;
                if (w_any_grant) begin
                    r_packet <= w_grant_pkt;
                    r_last   <= w_grant_idx;
                end
            end
            r_cnt <= w_cnt_next;
        end
    end

    assign etx_access = r_access;
    assign etx_packet = r_packet;

endmodule
